vin_pwmcapture: RTL

//  Multi-channel PWM input capture. Per channel: measures period and high time, in clk cycles, of an async PWM input.

---
 rtl/vin_pwmcapture_if.sv | 15 +
 rtl/vin_pwmcapture.sv | 103 ++++++++++
 2 files changed

// File: rtl/vin_pwmcapture_if.sv
// vin_pwmcapture_if: PWM input pins and per-channel capture results.
// The master side drives SIGNAL and reads the results; the capture block is the slave side.
interface vin_pwmcapture_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
);
    logic [CHANNELS-1:0]       SIGNAL;
    logic [CHANNELS*WIDTH-1:0] period;
    logic [CHANNELS*WIDTH-1:0] high_time;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       stale;
    logic [CHANNELS-1:0]       level;
    modport master (output SIGNAL, input period, high_time, valid, stale, level);
    modport slave  (input SIGNAL, output period, high_time, valid, stale, level);
endinterface

// File: rtl/vin_pwmcapture.sv
// vin_pwmcapture: per-channel PWM period/high-time capture in clk cycles, with timeout to stale.
// Define VIN_PWMCAPTURE_FILTER_EN to add a FILTER_LEN-cycle stability filter after the synchroniser.
module vin_pwmcapture #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 25000000,
    parameter int FILTER_LEN = 4
) (
    input logic             clk,
    input logic             rst_n,
    vin_pwmcapture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] TO      = WIDTH'(TIMEOUT);
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("FILTER_LEN must be at least 1");
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic s1, s2, s3, lvl, rise, fall;
        state_t state, state_n;
        logic [WIDTH-1:0] cnt, cnt_n, hi, hi_n, per, per_n, ht, ht_n;
        logic vld, vld_n, stl, stl_n;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) {s1, s2} <= '0;
            else {s1, s2} <= {bus.SIGNAL[c], s1};
`ifdef VIN_PWMCAPTURE_FILTER_EN
        localparam int FW = $clog2(FILTER_LEN + 1);
        localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
        logic [FW-1:0] fc;
        // fc counts consecutive cycles s2 disagrees with the filtered level
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                lvl <= 1'b0;
                fc  <= '0;
            end else if (s2 == lvl) fc <= '0;
            else if (fc == FMAX) begin
                lvl <= s2;
                fc  <= '0;
            end else fc <= fc + 1'b1;
`else
        assign lvl = s2;
`endif
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) s3 <= 1'b0;
            else s3 <= lvl;
        assign rise = lvl & ~s3;
        assign fall = ~lvl & s3;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
                hi    <= '0;
                per   <= '0;
                ht    <= '0;
                vld   <= 1'b0;
                stl   <= 1'b1;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                hi    <= hi_n;
                per   <= per_n;
                ht    <= ht_n;
                vld   <= vld_n;
                stl   <= stl_n;
            end
        // an edge always beats the timeout in the same cycle
        always_comb begin
            state_n = state;
            cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            hi_n    = hi;
            per_n   = per;
            ht_n    = ht;
            vld_n   = 1'b0;
            stl_n   = stl;
            if (state == IDLE) begin
                cnt_n = rise ? '0 : cnt;
                state_n = rise ? HIGH : IDLE;
            end else if (rise) begin
                state_n = HIGH;
                cnt_n   = '0;
                per_n   = cnt + 1'b1;
                ht_n    = hi;
                vld_n   = 1'b1;
                stl_n   = 1'b0;
            end else if (fall) begin
                hi_n    = (state == HIGH) ? cnt + 1'b1 : hi;
                state_n = LOW;
            end else if (cnt >= TO) begin
                state_n = IDLE;
                cnt_n   = '0;
                per_n   = '0;
                ht_n    = '0;
                stl_n   = 1'b1;
            end
        end
        assign bus.period[c*WIDTH +: WIDTH]    = per;
        assign bus.high_time[c*WIDTH +: WIDTH] = ht;
        assign bus.valid[c] = vld;
        assign bus.stale[c] = stl;
        assign bus.level[c] = lvl;
    end
endmodule
